// File: rtl/antares_divider_pkg.sv
// rtl/antares_divider_pkg.sv - shared FSM encoding and sizing for the Antares divider
package antares_divider_pkg;

   localparam int DIV_WIDTH_DEF = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_FIX  = 2'd2
   } div_state_e;

   function automatic int cnt_width(input int w);
      return (w <= 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/antares_divider_if.sv
// rtl/antares_divider_if.sv - execute-stage to divider request/result bundle
interface antares_divider_if #(parameter int W = 32);

   logic         op_divs;
   logic         op_divu;
   logic         flush;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_busy;
   logic         div_done;

   modport master (
      output op_divs, op_divu, flush, dividend, divisor,
      input  quotient, remainder, div_busy, div_done
   );

   modport slave (
      input  op_divs, op_divu, flush, dividend, divisor,
      output quotient, remainder, div_busy, div_done
   );

endinterface

// File: rtl/antares_div_step.sv
// rtl/antares_div_step.sv - one combinational restoring shift-subtract iteration
module antares_div_step #(
   parameter int W = 32
) (
   input  logic [W-1:0] rem_in,
   input  logic [W-1:0] q_in,
   input  logic [W-1:0] divisor,
   output logic [W-1:0] rem_out,
   output logic [W-1:0] q_out
);

   logic [W:0] partial;
   logic [W:0] diff;
   logic       ge;

   assign partial = {rem_in, q_in[W-1]};
   assign diff    = partial - {1'b0, divisor};
   // Since rem_in < divisor, a borrow always lands in the extra top bit.
   assign ge      = ~diff[W];
   assign rem_out = ge ? diff[W-1:0] : partial[W-1:0];
   assign q_out   = {q_in[W-2:0], ge};

endmodule

// File: rtl/antares_divider.sv
// rtl/antares_divider.sv - iterative restoring DIV/DIVU unit, one bit per clock
// Optional: ANTARES_DIV_ZERO_FAST_EN skips the iterations when the divisor is zero.
module antares_divider
   import antares_divider_pkg::*;
#(
   parameter int DIV_WIDTH = DIV_WIDTH_DEF
) (
   input logic                    clk,
   input logic                    rst_n,
   antares_divider_if.slave       dif
);

   localparam int CW = cnt_width(DIV_WIDTH);
`ifdef ANTARES_DIV_ZERO_FAST_EN
   localparam bit FAST_ZERO = 1'b1;
`else
   localparam bit FAST_ZERO = 1'b0;
`endif

   div_state_e             state_q, state_d;
   logic [CW-1:0]          cnt_q;
   logic [DIV_WIDTH-1:0]   rem_q, q_q, div_q;
   logic                   neg_q_q, neg_r_q;
   logic [DIV_WIDTH-1:0]   quo_out_q, rem_out_q;
   logic                   busy_q, done_q;

   logic                   start, sgn, a_neg, b_neg, b_zero;
   logic [DIV_WIDTH-1:0]   a_mag, b_mag, step_rem, step_q;

   assign sgn    = dif.op_divs;
   assign start  = (dif.op_divs | dif.op_divu) & ~dif.flush;
   assign a_neg  = sgn & dif.dividend[DIV_WIDTH-1];
   assign b_neg  = sgn & dif.divisor[DIV_WIDTH-1];
   assign a_mag  = a_neg ? -dif.dividend : dif.dividend;
   assign b_mag  = b_neg ? -dif.divisor : dif.divisor;
   assign b_zero = (dif.divisor == '0);

   antares_div_step #(.W(DIV_WIDTH)) u_step (
      .rem_in  (rem_q),
      .q_in    (q_q),
      .divisor (div_q),
      .rem_out (step_rem),
      .q_out   (step_q)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start) state_d = (FAST_ZERO && b_zero) ? ST_FIX : ST_BUSY;
         ST_BUSY: if (cnt_q == '0) state_d = ST_FIX;
         ST_FIX:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (dif.flush) state_d = ST_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         rem_q     <= '0;
         q_q       <= '0;
         div_q     <= '0;
         neg_q_q   <= 1'b0;
         neg_r_q   <= 1'b0;
         quo_out_q <= '0;
         rem_out_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (dif.flush) begin
            busy_q <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: if (start) begin
                  div_q   <= b_mag;
                  neg_q_q <= a_neg ^ b_neg;
                  neg_r_q <= a_neg;
                  cnt_q   <= CW'(DIV_WIDTH - 1);
                  busy_q  <= 1'b1;
                  // Preload what the iterations would produce for a zero divisor.
                  if (FAST_ZERO && b_zero) begin
                     rem_q <= a_mag;
                     q_q   <= '1;
                  end else begin
                     rem_q <= '0;
                     q_q   <= a_mag;
                  end
               end
               ST_BUSY: begin
                  rem_q <= step_rem;
                  q_q   <= step_q;
                  cnt_q <= cnt_q - 1'b1;
               end
               ST_FIX: begin
                  quo_out_q <= neg_q_q ? -q_q : q_q;
                  rem_out_q <= neg_r_q ? -rem_q : rem_q;
                  done_q    <= 1'b1;
                  busy_q    <= 1'b0;
               end
               default: busy_q <= 1'b0;
            endcase
         end
      end
   end

   assign dif.quotient  = quo_out_q;
   assign dif.remainder = rem_out_q;
   assign dif.div_busy  = busy_q;
   assign dif.div_done  = done_q;

endmodule

// File: tb/tb_antares_divider.sv
// tb/tb_antares_divider.sv - self-checking bench for antares_divider
module tb_antares_divider;

   localparam int W = 32;
`ifdef ANTARES_DIV_ZERO_FAST_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   antares_divider_if #(.W(W)) dif ();
   antares_divider #(.DIV_WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .dif(dif));

   int n_cmp = 0;
   int n_err = 0;
   int done_cnt = 0;

   always @(negedge clk) if (dif.div_done) done_cnt++;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      bit          sgn;
      logic [31:0] q;
      logic [31:0] r;
   } vec_t;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
      end
   endtask

   // Reference: language arithmetic plus the architectural special cases.
   function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                                   output logic [31:0] q, output logic [31:0] r);
      if (b == 0) begin
         r = a;
         q = (sgn && $signed(a) < 0) ? 32'd1 : 32'hFFFF_FFFF;
      end else if (!sgn) begin
         q = a / b;
         r = a % b;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000;
         r = 0;
      end else begin
         q = $signed(a) / $signed(b);
         r = $signed(a) % $signed(b);
      end
   endfunction

   function automatic int exp_lat(input logic [31:0] b);
      return (FAST && b == 0) ? 1 : 33;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit sgn);
      dif.dividend = a;
      dif.divisor  = b;
      dif.op_divs  = sgn;
      dif.op_divu  = !sgn;
      step();
      dif.op_divs  = 1'b0;
      dif.op_divu  = 1'b0;
   endtask

   task automatic wait_done(output int lat, output int busy_cyc);
      lat = 0;
      busy_cyc = 0;
      while (!dif.div_done && lat < 200) begin
         if (dif.div_busy) busy_cyc++;
         step();
         lat++;
      end
   endtask

   task automatic run_check(input string name, input logic [31:0] a, input logic [31:0] b,
                            input bit sgn, input bit chk_lat);
      logic [31:0] eq, er;
      int lat, bc;
      ref_div(a, b, sgn, eq, er);
      issue(a, b, sgn);
      wait_done(lat, bc);
      check({name, " done"}, dif.div_done, 1'b1);
      check({name, " quotient"}, dif.quotient, eq);
      check({name, " remainder"}, dif.remainder, er);
      if (chk_lat) begin
         check({name, " latency"}, lat, exp_lat(b));
         check({name, " busy cycles"}, bc, exp_lat(b));
      end
   endtask

   vec_t vecs[8];

   initial begin
      int lat, bc, dc0;
      logic [31:0] a, b;
      bit s;

      vecs[0] = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2};
      vecs[1] = '{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF};
      vecs[2] = '{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1};
      vecs[3] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0};
      vecs[4] = '{32'd5,          32'd0,          1'b0, 32'hFFFF_FFFF,  32'd5};
      vecs[5] = '{32'hFFFF_FFFB,  32'd0,          1'b1, 32'd1,          32'hFFFF_FFFB};
      vecs[6] = '{32'd50,         32'd5,          1'b0, 32'd10,         32'd0};
      vecs[7] = '{32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0};

      dif.op_divs = 0; dif.op_divu = 0; dif.flush = 0;
      dif.dividend = 0; dif.divisor = 0;
      repeat (3) step();
      check("reset quotient", dif.quotient, 0);
      check("reset remainder", dif.remainder, 0);
      check("reset busy", dif.div_busy, 0);
      check("reset done", dif.div_done, 0);
      rst_n = 1'b1;
      step();

      for (int i = 0; i < 8; i++) begin
         issue(vecs[i].a, vecs[i].b, vecs[i].sgn);
         wait_done(lat, bc);
         check($sformatf("vec%0d quotient", i), dif.quotient, vecs[i].q);
         check($sformatf("vec%0d remainder", i), dif.remainder, vecs[i].r);
         check($sformatf("vec%0d latency", i), lat, exp_lat(vecs[i].b));
         check($sformatf("vec%0d busy cycles", i), bc, exp_lat(vecs[i].b));
         step();
         check($sformatf("vec%0d done pulse", i), dif.div_done, 0);
         check($sformatf("vec%0d hold q", i), dif.quotient, vecs[i].q);
      end

      // Flush mid-operation: outputs hold 100/7 result, no done, restart next cycle.
      run_check("pre-flush", 32'd100, 32'd7, 1'b0, 1'b1);
      step();
      dc0 = done_cnt;
      issue(32'd50, 32'd5, 1'b0);
      repeat (9) step();
      dif.flush = 1'b1;
      step();
      dif.flush = 1'b0;
      check("flush busy", dif.div_busy, 0);
      check("flush quotient kept", dif.quotient, 32'd14);
      check("flush remainder kept", dif.remainder, 32'd2);
      check("flush no done", done_cnt, dc0);
      run_check("post-flush", 32'd50, 32'd5, 1'b0, 1'b1);

      // Flush and start together in IDLE: nothing starts.
      step();
      dif.flush = 1'b1;
      issue(32'd9, 32'd3, 1'b0);
      dif.flush = 1'b0;
      check("flush+start busy", dif.div_busy, 0);
      step();
      check("flush+start busy later", dif.div_busy, 0);

      // Second start while busy is ignored.
      issue(32'd100, 32'd7, 1'b0);
      repeat (4) step();
      dif.dividend = 32'd9; dif.divisor = 32'd3; dif.op_divu = 1'b1;
      step();
      dif.op_divu = 1'b0;
      wait_done(lat, bc);
      check("ignore quotient", dif.quotient, 32'd14);
      check("ignore remainder", dif.remainder, 32'd2);
      check("ignore latency", lat + 5, 33);

      // Back-to-back start in the done cycle.
      dc0 = done_cnt;
      run_check("b2b", 32'd1000, 32'd3, 1'b0, 1'b1);
      check("b2b done count", done_cnt, dc0 + 1);

      // Asynchronous reset mid-operation.
      issue(32'd77, 32'd6, 1'b0);
      repeat (19) step();
      dc0 = done_cnt;
      rst_n = 1'b0;
      #1;
      check("arst quotient", dif.quotient, 0);
      check("arst remainder", dif.remainder, 0);
      check("arst busy", dif.div_busy, 0);
      repeat (2) step();
      rst_n = 1'b1;
      repeat (40) step();
      check("arst no done", done_cnt, dc0);
      run_check("post-reset", 32'd77, 32'd6, 1'b0, 1'b1);

      // Randomized operations against the reference.
      for (int i = 0; i < 40; i++) begin
         a = $urandom;
         if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
         case ($urandom_range(0, 3))
            0: b = 0;
            1: b = $urandom_range(1, 15);
            2: b = $urandom;
            default: b = 32'hFFFF_FFFF;
         endcase
         s = 1'($urandom_range(0, 1));
         run_check($sformatf("rnd%0d", i), a, b, s, 1'b1);
         if ($urandom_range(0, 1) == 1) step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
